// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM state type and opcode encodings
// for the sequential control unit.
package cpu_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_HALT
   } state_t;

   function automatic int op_halt(input int w);
      return (1 << w) - 1;
   endfunction

   function automatic int op_jmp(input int w);
      return (1 << w) - 2;
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: splits an instruction word into opcode,
// register select and immediate fields.
module instr_decoder
   import cpu_pkg::*;
#(
   parameter int INSTR_W = 8,
   parameter int OP_W    = 2,
   parameter int RSEL_W  = 2
)(
   input  logic [INSTR_W-1:0]             instr,
   output logic [OP_W-1:0]                op,
   output logic [RSEL_W-1:0]              reg_sel,
   output logic [INSTR_W-OP_W-RSEL_W-1:0] imm
);

   localparam int IMM_W = INSTR_W - OP_W - RSEL_W;

   assign op      = instr[INSTR_W-1 -: OP_W];
   assign reg_sel = instr[INSTR_W-OP_W-1 -: RSEL_W];
   assign imm     = instr[IMM_W-1:0];

endmodule

// File: rtl/seq_control_unit.sv
// seq_control_unit: fetch/decode/execute sequencer with
// pc, instruction register and datapath handshake.
module seq_control_unit
   import cpu_pkg::*;
#(
   parameter int INSTR_W = 8,
   parameter int OP_W    = 2,
   parameter int RSEL_W  = 2,
   parameter int ADDR_W  = 4
)(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   output logic                           imem_req,
   output logic [ADDR_W-1:0]              imem_addr,
   input  logic                           imem_valid,
   input  logic [INSTR_W-1:0]             imem_rdata,
   output logic                           exec_valid,
   input  logic                           exec_ready,
   output logic [OP_W-1:0]                op,
   output logic [RSEL_W-1:0]              reg_sel,
   output logic [INSTR_W-OP_W-RSEL_W-1:0] imm,
   output logic [ADDR_W-1:0]              pc,
   output logic                           busy,
   output logic                           halted
);

   localparam int IMM_W = INSTR_W - OP_W - RSEL_W;
   localparam logic [OP_W-1:0] OPC_HALT = OP_W'(op_halt(OP_W));
   localparam logic [OP_W-1:0] OPC_JMP  = OP_W'(op_jmp(OP_W));

   if (IMM_W < 1) begin : g_imm_chk
      $error("seq_control_unit: immediate field width must be >= 1");
   end

   state_t             state;
   logic [INSTR_W-1:0] ir;
   logic [ADDR_W-1:0]  jmp_pc;

   instr_decoder #(
      .INSTR_W (INSTR_W),
      .OP_W    (OP_W),
      .RSEL_W  (RSEL_W)
   ) u_dec (
      .instr   (ir),
      .op      (op),
      .reg_sel (reg_sel),
      .imm     (imm)
   );

   // jump target: immediate fitted to the pc width
   if (IMM_W >= ADDR_W) begin : g_trunc
      assign jmp_pc = imm[ADDR_W-1:0];
   end else begin : g_zext
      assign jmp_pc = {{(ADDR_W-IMM_W){1'b0}}, imm};
   end

   assign imem_addr = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         pc         <= '0;
         ir         <= '0;
         imem_req   <= 1'b0;
         exec_valid <= 1'b0;
         busy       <= 1'b0;
         halted     <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  pc       <= '0;
                  state    <= S_FETCH;
                  imem_req <= 1'b1;
                  busy     <= 1'b1;
                  halted   <= 1'b0;
               end
            end
            S_FETCH: begin
               if (imem_valid) begin
                  ir       <= imem_rdata;
                  imem_req <= 1'b0;
                  state    <= S_DECODE;
               end
            end
            S_DECODE: begin
               unique case (1'b1)
                  (op == OPC_HALT): begin
                     state  <= S_HALT;
                     busy   <= 1'b0;
                     halted <= 1'b1;
                  end
                  (op == OPC_JMP): begin
                     pc       <= jmp_pc;
                     state    <= S_FETCH;
                     imem_req <= 1'b1;
                  end
                  default: begin
                     state      <= S_EXEC;
                     exec_valid <= 1'b1;
                  end
               endcase
            end
            S_EXEC: begin
               if (exec_ready) begin
                  pc         <= pc + 1'b1;
                  exec_valid <= 1'b0;
                  imem_req   <= 1'b1;
                  state      <= S_FETCH;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_control_unit.sv
// tb_seq_control_unit: random programs checked against an
// instruction-level reference model through a scoreboard.
module tb_seq_control_unit;

   localparam int STEPS = 16;
   localparam int TMO   = 3000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_cmd = 1'b0;
   logic       start_noise = 1'b0;
   logic       start;
   logic       imem_valid = 1'b0;
   logic       exec_ready = 1'b0;
   logic [7:0] imem_rdata = 8'h00;
   logic       imem_req, exec_valid, busy, halted;
   logic [3:0] imem_addr, pc, imm;
   logic [1:0] op, reg_sel;

   assign start = start_cmd | start_noise;

   always #5 clk = ~clk;

   seq_control_unit #(
      .INSTR_W (8),
      .OP_W    (2),
      .RSEL_W  (2),
      .ADDR_W  (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_valid (imem_valid),
      .imem_rdata (imem_rdata),
      .exec_valid (exec_valid),
      .exec_ready (exec_ready),
      .op         (op),
      .reg_sel    (reg_sel),
      .imm        (imm),
      .pc         (pc),
      .busy       (busy),
      .halted     (halted)
   );

   logic [7:0]  mem [16];
   logic [3:0]  fetch_q [$];
   logic [11:0] exec_q [$];
   bit          exp_halt;
   logic [3:0]  exp_halt_pc;
   bit          halt_seen = 1'b0;
   bit          chk_en = 1'b0;
   int          max_dly = 0;
   int          rdy_pct = 100;
   int          start_pct = 0;
   int          vectors = 0;
   int          errors = 0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h",
                  name, act, exp);
      end
   endtask

   task automatic fail(input string name, input string what);
      vectors++;
      errors++;
      $display("FAIL %s: got %s", name, what);
   endtask

   // ISA-level model: walk the program from address 0
   task automatic build_model();
      int p;
      logic [7:0] ins;
      p = 0;
      fetch_q.delete();
      exec_q.delete();
      exp_halt = 1'b0;
      exp_halt_pc = 4'h0;
      for (int s = 0; s < STEPS; s++) begin
         ins = mem[p];
         fetch_q.push_back(4'(p));
         if (ins[7:6] == 2'd3) begin
            exp_halt = 1'b1;
            exp_halt_pc = 4'(p);
            break;
         end else if (ins[7:6] == 2'd2) begin
            p = int'(ins[3:0]);
         end else begin
            exec_q.push_back({ins[7:4], ins[3:0], 4'(p)});
            p = (p + 1) % 16;
         end
      end
   endtask

   // memory responder, datapath ready and stray start pulses
   initial begin
      int wcnt, dly;
      wcnt = 0;
      dly = 0;
      forever begin
         @(posedge clk);
         #1;
         exec_ready = ($urandom_range(0, 99) < rdy_pct);
         start_noise = busy && ($urandom_range(0, 99) < start_pct);
         if (imem_req) begin
            if (wcnt >= dly) begin
               imem_valid = 1'b1;
               imem_rdata = mem[imem_addr];
            end else begin
               imem_valid = 1'b0;
               imem_rdata = 8'($urandom);
               wcnt++;
            end
         end else begin
            imem_valid = 1'($urandom_range(0, 1));
            imem_rdata = 8'($urandom);
            wcnt = 0;
            dly = $urandom_range(0, max_dly);
         end
      end
   end

   always @(negedge clk) begin
      if (!chk_en) begin
         halt_seen = 1'b0;
      end else if (rst_n) begin
         if (imem_req && imem_valid) begin
            if (fetch_q.size() == 0)
               fail("fetch_extra", $sformatf("fetch @%0h", imem_addr));
            else
               check("fetch_addr", 32'(imem_addr), 32'(fetch_q.pop_front()));
         end
         if (exec_valid) begin
            if (exec_q.size() == 0) begin
               fail("exec_extra", $sformatf("op %0h pc %0h", op, pc));
            end else begin
               check("exec_fields", 32'({op, reg_sel, imm, pc}),
                     32'(exec_q[0]));
               if (exec_ready)
                  void'(exec_q.pop_front());
            end
         end
         if (halted && !halt_seen) begin
            halt_seen = 1'b1;
            check("halt_expected", 32'(1), 32'(exp_halt));
            check("halt_pc", 32'(pc), 32'(exp_halt_pc));
            check("halt_busy", 32'(busy), 32'(0));
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk);
      #1 start_cmd = 1'b1;
      @(posedge clk);
      #1 start_cmd = 1'b0;
   endtask

   task automatic one_pass(input bit measure);
      int n;
      build_model();
      chk_en = 1'b1;
      pulse_start();
      if (measure) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!(exec_valid && exec_ready) && n < 20);
         check("latency", 32'(n), 32'(3));
      end
      n = 0;
      while (!(fetch_q.size() == 0 && exec_q.size() == 0 &&
               (!exp_halt || halt_seen)) && n < TMO) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= TMO)
         fail("completion", "timeout");
   endtask

   task automatic do_reset_check();
      #2 rst_n = 1'b0;
      #1;
      check("rst_outputs",
            32'({imem_req, exec_valid, busy, halted, pc,
                 imem_addr, op, reg_sel, imm}), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("idle_hold", 32'({busy, imem_req, halted, pc}), 32'(0));
      end
   endtask

   task automatic run_prog(input int mdly, input int rdy,
                           input int spct, input bit measure);
      max_dly = mdly;
      rdy_pct = rdy;
      start_pct = spct;
      one_pass(measure);
      if (exp_halt) begin
         chk_en = 1'b0;
         @(negedge clk);
         #1;
         one_pass(1'b0);
      end
      chk_en = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_reset_check();
   endtask

   task automatic fill_halt();
      for (int i = 0; i < 16; i++) mem[i] = 8'hC0;
   endtask

   initial begin
      int n;
      fill_halt();
      #3;
      check("reset_state",
            32'({imem_req, exec_valid, busy, halted, pc,
                 imem_addr, op, reg_sel, imm}), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;

      fill_halt();
      mem[0] = 8'h5A;
      run_prog(0, 100, 0, 1'b1);

      fill_halt();
      mem[0] = 8'h27;
      run_prog(0, 25, 0, 1'b0);

      for (int i = 0; i < 16; i++) mem[i] = 8'h11 + 8'(i);
      mem[0] = 8'hB9;
      mem[9] = 8'hC0;
      run_prog(3, 50, 30, 1'b0);

      fill_halt();
      mem[0] = 8'hBF;
      mem[15] = 8'h12;
      run_prog(2, 60, 20, 1'b0);

      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < 16; i++) begin
            mem[i] = 8'($urandom);
            if (mem[i][7:6] == 2'd3 && $urandom_range(0, 3) != 0)
               mem[i][7:6] = 2'($urandom_range(0, 2));
         end
         run_prog($urandom_range(0, 3), $urandom_range(20, 100),
                  $urandom_range(0, 40), 1'b0);
      end

      // abort while an operation is being offered
      fill_halt();
      mem[0] = 8'h5A;
      max_dly = 1;
      rdy_pct = 0;
      start_pct = 0;
      pulse_start();
      n = 0;
      while (!exec_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!exec_valid)
         fail("mid_exec_reach", "timeout");
      repeat (2) @(negedge clk);
      check("mid_exec_pc", 32'(pc), 32'(0));
      do_reset_check();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule

// File: doc/seq_control_unit.md
SEQ_CONTROL_UNIT -- requirements
Module: seq_control_unit

Interface
REQ-001 The block SHALL have parameter INSTR_W, default 8: instruction width in bits.
REQ-002 The block SHALL have parameter OP_W, default 2: opcode field width, in instruction bits [INSTR_W-1 -: OP_W].
REQ-003 The block SHALL have parameter RSEL_W, default 2: register-select field width, in the bits directly below the opcode.
REQ-004 The block SHALL have parameter ADDR_W, default 4: program-counter and instruction-memory address width.
REQ-005 The block SHALL derive IMM_W = INSTR_W-OP_W-RSEL_W from the low bits of the instruction; elaboration SHALL fail if IMM_W<1.
REQ-006 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 Port start, input, 1: single-cycle run request.
REQ-009 Port imem_req, output, 1: fetch request to instruction memory.
REQ-010 Port imem_addr, output, ADDR_W: fetch address; equals pc.
REQ-011 Port imem_valid, input, 1: imem_rdata is valid this cycle.
REQ-012 Port imem_rdata, input, INSTR_W: fetched instruction.
REQ-013 Port exec_valid, output, 1: decoded operation offered to the datapath.
REQ-014 Port exec_ready, input, 1: the datapath accepts the offered operation.
REQ-015 Port op, output, OP_W: decoded opcode.
REQ-016 Port reg_sel, output, RSEL_W: decoded register select.
REQ-017 Port imm, output, IMM_W: decoded immediate.
REQ-018 Port pc, output, ADDR_W: current program counter.
REQ-019 Port busy, output, 1: high in FETCH, DECODE and EXECUTE.
REQ-020 Port halted, output, 1: high in HALT.

Function
REQ-021 The FSM SHALL have the states IDLE, FETCH, DECODE, EXECUTE and HALT.
REQ-022 IDLE: on start=1, set pc to 0 and go to FETCH next cycle; otherwise stay.
REQ-023 FETCH: drive imem_req=1 and imem_addr=pc, and hold both until imem_valid=1.
REQ-024 FETCH with imem_valid=1: latch imem_rdata into the instruction register and go to DECODE; imem_valid outside FETCH SHALL be ignored.
REQ-025 DECODE: lasts exactly 1 cycle; op, reg_sel and imm SHALL come from the instruction register and stay stable until the next fetch is latched.
REQ-026 DECODE, op all-ones (OP_HALT): go to HALT; pc is unchanged.
REQ-027 DECODE, op all-ones minus 1 (OP_JMP): set pc to imm (zero-extended or truncated to ADDR_W) and go to FETCH; exec_valid is not raised.
REQ-028 DECODE, any other op: go to EXECUTE.
REQ-029 EXECUTE: drive exec_valid=1 and hold it with stable fields until exec_ready=1.
REQ-030 On the exec_valid&&exec_ready cycle: increment pc (modulo 2^ADDR_W, so all-ones wraps to 0) and go to FETCH.
REQ-031 Minimum latency is 3 cycles per non-jump instruction (FETCH with imem_valid already high, DECODE, EXECUTE with exec_ready already high).
REQ-032 HALT: on start=1, set pc to 0 and go to FETCH; otherwise stay.
REQ-033 start SHALL be ignored in FETCH, DECODE and EXECUTE.
REQ-034 exec_ready without exec_valid SHALL have no effect.

Reset
REQ-035 While rst_n=0: state=IDLE, and pc, instruction register, imem_req, imem_addr, exec_valid, op, reg_sel, imm, busy and halted SHALL all be 0.
REQ-036 Reset asserted in any state, including mid-handshake, SHALL abort the operation immediately with no pc update.
REQ-037 After rst_n deasserts, the first possible transition SHALL be on the first rising edge with start=1.

Structure
REQ-038 The state enum type and the OP_HALT/OP_JMP encoding functions SHALL live in shared package cpu_pkg.
REQ-039 A sub-module instr_decoder (combinational field split, parametrised like the top) SHALL be used.
REQ-040 The FSM, pc and instruction register SHALL reside in the top module.

Verification (defaults INSTR_W=8, OP_W=2, RSEL_W=2, ADDR_W=4)
REQ-041 Reset mid-EXECUTE with exec_valid=1 -> next cycle exec_valid=0, state IDLE, pc=0.
REQ-042 start; mem[0]=8'h5A, imem_valid and exec_ready tied high -> op=2'b01, reg_sel=2'b01, imm=4'hA, exec_valid 1 cycle, pc=1, 3 cycles total.
REQ-043 mem[0]=8'h27, exec_ready held low 4 cycles -> exec_valid high 5 cycles with fields unchanged, then pc=1.
REQ-044 mem[0]=8'hB9 (JMP) -> no exec_valid, next imem_addr=4'h9; then mem[9]=8'hC0 (HALT) -> halted=1, busy=0, pc=9.
REQ-045 Program counting up from pc=4'hF with a non-jump op -> pc wraps to 0, next imem_addr=0.
REQ-046 imem_valid delayed 3 cycles, start pulsed during FETCH -> imem_req held 4 cycles, start ignored, single instruction executed.
